// File: rtl/ultrasound_scan_scheduler.sv
// Scans NUM_CHANNELS transducers once per run (settle, trigger, time echo) and keeps the nearest valid distance.
// Per channel SETTLE+TRIGGER+echo wait+width+1 cycles; run is only sampled in IDLE, so requests while busy are dropped.
module ultrasound_scan_scheduler #(
  parameter int NUM_CHANNELS    = 12,
  parameter int SETTLE_CYCLES   = 27000,
  parameter int TRIGGER_CYCLES  = 270,
  parameter int TIMEOUT_CYCLES  = 1000000,
  parameter int CYCLES_PER_UNIT = 1566
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       run,
  input  logic       echo,
  output logic       trigger,
  output logic [3:0] channel,
  output logic       busy,
  output logic       done,
  output logic       found,
  output logic [7:0] nearest_distance,
  output logic [3:0] nearest_channel,
  output logic [2:0] state
);

  localparam int CW = $clog2(((SETTLE_CYCLES > TRIGGER_CYCLES) ? SETTLE_CYCLES : TRIGGER_CYCLES) + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int PW = $clog2(CYCLES_PER_UNIT + 1);

  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] TRIG_LAST   = CW'(TRIGGER_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST    = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [PW-1:0] PRESC_LAST  = PW'(CYCLES_PER_UNIT - 1);
  localparam logic [3:0]    LAST_CH     = 4'(NUM_CHANNELS - 1);
  // The rise is detected on the first synced-high cycle, so that cycle is already counted.
  localparam logic [PW-1:0] PRESC_INIT  = (CYCLES_PER_UNIT == 1) ? PW'(0) : PW'(1);
  localparam logic [7:0]    DIST_INIT   = (CYCLES_PER_UNIT == 1) ? 8'd1 : 8'd0;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SETTLE    = 3'd1,
    S_TRIGGER   = 3'd2,
    S_WAIT_RISE = 3'd3,
    S_MEASURE   = 3'd4,
    S_RECORD    = 3'd5,
    S_DONE      = 3'd6
  } state_t;

  state_t        r_state;
  logic          r_echo_s1;
  logic          r_echo_s2;
  logic          r_echo_d;
  logic [CW-1:0] r_cnt;
  logic [TW-1:0] r_tmo;
  logic [PW-1:0] r_presc;
  logic [7:0]    r_dist;
  logic          r_valid;
  logic          r_trigger;
  logic [3:0]    r_channel;
  logic          r_busy;
  logic          r_done;
  logic          r_found;
  logic [7:0]    r_near_dist;
  logic [3:0]    r_near_ch;

  logic w_rise;
  logic w_fall;
  logic w_tmo;
  logic w_better;

  assign w_rise   = r_echo_s2 & ~r_echo_d;
  assign w_fall   = ~r_echo_s2 & r_echo_d;
  assign w_tmo    = (r_tmo >= TMO_LAST);
  // A saturated reading only counts when nothing else has been found yet.
  assign w_better = r_valid & ((r_dist < r_near_dist) |
                    (~r_found & (r_near_dist == 8'hFF) & (r_dist == 8'hFF)));

  assign trigger          = r_trigger;
  assign channel          = r_channel;
  assign busy             = r_busy;
  assign done             = r_done;
  assign found            = r_found;
  assign nearest_distance = r_near_dist;
  assign nearest_channel  = r_near_ch;
  assign state            = r_state;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_echo_s1   <= 1'b0;
      r_echo_s2   <= 1'b0;
      r_echo_d    <= 1'b0;
      r_cnt       <= '0;
      r_tmo       <= '0;
      r_presc     <= '0;
      r_dist      <= 8'd0;
      r_valid     <= 1'b0;
      r_trigger   <= 1'b0;
      r_channel   <= 4'd0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_found     <= 1'b0;
      r_near_dist <= 8'hFF;
      r_near_ch   <= 4'd0;
    end else begin
      r_echo_s1 <= echo;
      r_echo_s2 <= r_echo_s1;
      r_echo_d  <= r_echo_s2;
      case (r_state)
        S_IDLE: begin
          if (run) begin
            r_found     <= 1'b0;
            r_near_dist <= 8'hFF;
            r_near_ch   <= 4'd0;
            r_channel   <= 4'd0;
            r_cnt       <= '0;
            r_busy      <= 1'b1;
            r_state     <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (r_cnt == SETTLE_LAST) begin
            r_cnt     <= '0;
            r_trigger <= 1'b1;
            r_state   <= S_TRIGGER;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_TRIGGER: begin
          if (r_cnt == TRIG_LAST) begin
            r_cnt     <= '0;
            r_trigger <= 1'b0;
            r_tmo     <= '0;
            r_state   <= S_WAIT_RISE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_WAIT_RISE: begin
          r_tmo <= r_tmo + 1'b1;
          if (w_rise) begin
            r_presc <= PRESC_INIT;
            r_dist  <= DIST_INIT;
            r_state <= S_MEASURE;
          end else if (w_tmo) begin
            r_valid <= 1'b0;
            r_state <= S_RECORD;
          end
        end
        S_MEASURE: begin
          r_tmo <= r_tmo + 1'b1;
          if (w_fall) begin
            r_valid <= 1'b1;
            r_state <= S_RECORD;
          end else if (w_tmo) begin
            r_valid <= 1'b0;
            r_state <= S_RECORD;
          end else if (r_echo_s2) begin
            if (r_presc == PRESC_LAST) begin
              r_presc <= '0;
              if (r_dist != 8'hFF) r_dist <= r_dist + 8'd1;
            end else begin
              r_presc <= r_presc + 1'b1;
            end
          end
        end
        S_RECORD: begin
          if (w_better) begin
            r_near_dist <= r_dist;
            r_near_ch   <= r_channel;
            r_found     <= 1'b1;
          end
          if (r_channel == LAST_CH) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_channel <= r_channel + 4'd1;
            r_cnt     <= '0;
            r_state   <= S_SETTLE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_trigger <= 1'b0;
          r_done    <= 1'b0;
          r_busy    <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule
